// File: rtl/mem_rw_bank_arbiter.sv
// ---------------------------------------------------------------------------
// mem_rw_bank_arbiter
//
// Purpose:
//   Merges the read-side (port 0) and write-side (port 1) memory ports of one
//   physical bank onto a single-port SRAM macro. A round-robin arbiter grants
//   at most one port per cycle. A shift pipeline of {valid, port_id} follows
//   each access through the SRAM latency so the response comes back to the
//   port that issued it, in grant order.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   in_req_i/in_gnt_o   per-port request / combinational grant ([0]=read side)
//   in_addr_i, in_wdata_i, in_strb_i, in_we_i, in_atop_i
//                       per-port access fields, packed port 1 above port 0
//   in_rvalid_o/in_rdata_o
//                       per-port response (read data, or write acknowledge)
//   sram_*              single-port SRAM interface; sram_rdata_i is valid
//                       MemLatency cycles after sram_req_o
//   atop_err_o          sticky: a granted access carried a non-zero atop
//   busy_o              registered: some access is still in flight
//
// Optional feature (macro MEM_RW_BANK_ARBITER_RDATA_REG_EN):
//   Registers in_rvalid_o / in_rdata_o after the response pipeline, adding
//   one cycle of latency; busy_o then also covers that register.
// ---------------------------------------------------------------------------
module mem_rw_bank_arbiter #(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned MemLatency = 1,
  parameter int unsigned StrbWidth  = DataWidth / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               in_req_i,
  output logic [1:0]               in_gnt_o,
  input  logic [2*AddrWidth-1:0]   in_addr_i,
  input  logic [2*DataWidth-1:0]   in_wdata_i,
  input  logic [2*StrbWidth-1:0]   in_strb_i,
  input  logic [1:0]               in_we_i,
  input  logic [11:0]              in_atop_i,
  output logic [1:0]               in_rvalid_o,
  output logic [2*DataWidth-1:0]   in_rdata_o,
  output logic                     sram_req_o,
  output logic                     sram_we_o,
  output logic [AddrWidth-1:0]     sram_addr_o,
  output logic [DataWidth-1:0]     sram_wdata_o,
  output logic [StrbWidth-1:0]     sram_be_o,
  input  logic [DataWidth-1:0]     sram_rdata_i,
  output logic                     atop_err_o,
  output logic                     busy_o
);

  if ((MemLatency < 1) || (MemLatency > 8)) begin : g_bad_latency
    $error("mem_rw_bank_arbiter: MemLatency must be in 1..8");
  end
  if ((DataWidth % 8) != 0) begin : g_bad_width
    $error("mem_rw_bank_arbiter: DataWidth must be a multiple of 8");
  end

  // r_rr_ptr names the port that wins when both request (0 after reset).
  logic                  r_rr_ptr;
  logic [1:0]            w_gnt;
  logic                  w_sel;
  logic                  w_atop_hit;
  logic [MemLatency-1:0] r_vld_p;
  logic [MemLatency-1:0] r_pid_p;
  logic [MemLatency-1:0] w_vld_nxt;
  logic [MemLatency-1:0] w_pid_nxt;
  logic                  w_fin_vld;
  logic                  w_fin_pid;
  logic [1:0]            w_rvalid;
  logic [2*DataWidth-1:0] w_rdata;
  logic                  w_busy_nxt;
  logic                  r_busy;
  logic                  r_atop_err;

  always_comb begin
    w_gnt = 2'b00;
    case (in_req_i)
      2'b01:   w_gnt = 2'b01;
      2'b10:   w_gnt = 2'b10;
      2'b11:   w_gnt = r_rr_ptr ? 2'b10 : 2'b01;
      default: w_gnt = 2'b00;
    endcase
  end

  assign in_gnt_o = w_gnt;
  assign w_sel    = w_gnt[1];

  always_comb begin
    sram_req_o   = |w_gnt;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    w_atop_hit   = 1'b0;
    if (sram_req_o) begin
      sram_we_o    = in_we_i[w_sel];
      sram_addr_o  = w_sel ? in_addr_i[2*AddrWidth-1:AddrWidth]
                           : in_addr_i[AddrWidth-1:0];
      sram_wdata_o = w_sel ? in_wdata_i[2*DataWidth-1:DataWidth]
                           : in_wdata_i[DataWidth-1:0];
      if (sram_we_o) begin
        sram_be_o = w_sel ? in_strb_i[2*StrbWidth-1:StrbWidth]
                          : in_strb_i[StrbWidth-1:0];
      end else begin
        sram_be_o = '1;
      end
      w_atop_hit = w_sel ? (in_atop_i[11:6] != 6'd0) : (in_atop_i[5:0] != 6'd0);
    end
  end

  // Pointer only advances on contention so a lone requester never steals
  // the other port's next turn.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr   <= 1'b0;
      r_atop_err <= 1'b0;
    end else begin
      if (&in_req_i) r_rr_ptr <= ~r_rr_ptr;
      if (w_atop_hit) r_atop_err <= 1'b1;
    end
  end

  assign atop_err_o = r_atop_err;

  // ---- stage 0 .. MemLatency-1: {valid, port_id} tracks the SRAM latency
  if (MemLatency == 1) begin : g_shift_one
    assign w_vld_nxt = sram_req_o;
    assign w_pid_nxt = w_sel;
  end else begin : g_shift_multi
    assign w_vld_nxt = {r_vld_p[MemLatency-2:0], sram_req_o};
    assign w_pid_nxt = {r_pid_p[MemLatency-2:0], w_sel};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld_p <= '0;
      r_pid_p <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_vld_p <= w_vld_nxt;
      r_pid_p <= w_pid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign w_fin_vld = r_vld_p[MemLatency-1];
  assign w_fin_pid = r_pid_p[MemLatency-1];

  // ---- response steering: final stage selects which port sees sram_rdata_i
  always_comb begin
    w_rvalid = 2'b00;
    w_rdata  = '0;
    if (w_fin_vld) begin
      if (w_fin_pid) begin
        w_rvalid                          = 2'b10;
        w_rdata[2*DataWidth-1:DataWidth] = sram_rdata_i;
      end else begin
        w_rvalid                = 2'b01;
        w_rdata[DataWidth-1:0] = sram_rdata_i;
      end
    end
  end

`ifdef MEM_RW_BANK_ARBITER_RDATA_REG_EN
  logic [1:0]             r_rvalid;
  logic [2*DataWidth-1:0] r_rdata;

  // ---- output register stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 2'b00;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rvalid;
      r_rdata  <= w_rdata;
    end
  end

  assign in_rvalid_o = r_rvalid;
  assign in_rdata_o  = r_rdata;
  // Next-cycle view: pipeline occupancy plus a response about to be latched.
  assign w_busy_nxt  = (|w_vld_nxt) | (|w_rvalid);
`else
  assign in_rvalid_o = w_rvalid;
  assign in_rdata_o  = w_rdata;
  assign w_busy_nxt  = |w_vld_nxt;
`endif

  assign busy_o = r_busy;

endmodule
